// File: rtl/cu_pkg.sv
// Shared types for the pipelined control decoder: opcodes, select codes,
// the registered control bundle, FSM states and the decode table.
// Optional build macro: CU_RV32M_EN enables multiply/divide decode.
package cu_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  localparam logic [2:0] PC_NEXT   = 3'd0;
  localparam logic [2:0] PC_JALR   = 3'd1;
  localparam logic [2:0] PC_BRANCH = 3'd2;
  localparam logic [2:0] PC_JAL    = 3'd3;
  localparam logic [2:0] PC_TRAP   = 3'd4;
  localparam logic [2:0] PC_MEPC   = 3'd5;

  localparam logic [1:0] WR_PC4 = 2'd0;
  localparam logic [1:0] WR_CSR = 2'd1;
  localparam logic [1:0] WR_MEM = 2'd2;
  localparam logic [1:0] WR_ALU = 2'd3;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_LUI = 4'd9;

  localparam logic [31:0] MRET = 32'h30200073;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_TRAP
  } state_t;

  typedef struct packed {
    logic [3:0] alu_fun;
    logic       alu_scra;
    logic [1:0] alu_scrb;
    logic [1:0] rf_wr_sel;
    logic [2:0] pc_source;
    logic [2:0] br_cond;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       is_mdu;
    logic [2:0] mdu_fun;
    logic       illegal;
    logic       int_taken;
    logic       is_mret;
  } ctrl_bundle_t;

  function automatic ctrl_bundle_t decode(
    input logic [31:0] instr
  );
    ctrl_bundle_t b;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    b  = '0;
    op = instr[6:0];
    f3 = instr[14:12];
    f7 = instr[31:25];
    unique case (1'b1)
      (op == OP_LUI): begin
        b.alu_fun   = ALU_LUI;
        b.alu_scra  = 1'b1;
        b.rf_wr_sel = WR_ALU;
        b.reg_write = 1'b1;
      end
      (op == OP_AUIPC): begin
        b.alu_scra  = 1'b1;
        b.alu_scrb  = 2'd3;
        b.rf_wr_sel = WR_ALU;
        b.reg_write = 1'b1;
      end
      (op == OP_JAL): begin
        b.pc_source = PC_JAL;
        b.rf_wr_sel = WR_PC4;
        b.reg_write = 1'b1;
      end
      (op == OP_JALR): begin
        b.pc_source = PC_JALR;
        b.rf_wr_sel = WR_PC4;
        b.reg_write = 1'b1;
      end
      (op == OP_BRANCH): begin
        b.pc_source = PC_BRANCH;
        b.br_cond   = f3;
        b.illegal   = (f3 == 3'd2) || (f3 == 3'd3);
      end
      (op == OP_LOAD): begin
        b.alu_scrb  = 2'd1;
        b.rf_wr_sel = WR_MEM;
        b.mem_read  = 1'b1;
        b.reg_write = 1'b1;
      end
      (op == OP_STORE): begin
        b.alu_scrb  = 2'd2;
        b.mem_write = 1'b1;
      end
      (op == OP_IMM): begin
        b.alu_fun   = {(f3 == 3'd5) & f7[5], f3};
        b.alu_scrb  = 2'd1;
        b.rf_wr_sel = WR_ALU;
        b.reg_write = 1'b1;
      end
      (op == OP_REG): begin
        if (f7 == 7'b0000001) begin
`ifdef CU_RV32M_EN
          b.alu_fun   = {f7[5], f3};
          b.is_mdu    = 1'b1;
          b.mdu_fun   = f3;
          b.rf_wr_sel = WR_ALU;
          b.reg_write = 1'b1;
`else
          b.illegal   = 1'b1;
`endif
        end else begin
          b.alu_fun   = {f7[5], f3};
          b.rf_wr_sel = WR_ALU;
          b.reg_write = 1'b1;
        end
      end
      (op == OP_SYSTEM): begin
        b.alu_fun   = ALU_LUI;
        b.rf_wr_sel = WR_CSR;
        b.reg_write = 1'b1;
        b.pc_source = (f3 == 3'd0) ? PC_MEPC : PC_NEXT;
      end
      default: b.illegal = 1'b1;
    endcase
    b.is_mret = (instr == MRET);
    return b;
  endfunction

endpackage

// File: rtl/cu_decode_pipe_if.sv
// Fetch-side and execute-side handshakes plus the control bundle fields.
// master: fetch/execute side; slave: the decode stage.
interface cu_decode_pipe_if #(
  parameter int NUM_INT = 4
);
  localparam int CAUSE_W =
    ($clog2(NUM_INT) > 0) ? $clog2(NUM_INT) : 1;

  logic               IN_VALID;
  logic               IN_READY;
  logic [31:0]        INSTR;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic [3:0]         ALU_FUN;
  logic               ALU_SCRA;
  logic [1:0]         ALU_SCRB;
  logic [1:0]         RF_WR_SEL;
  logic [2:0]         PC_SOURCE;
  logic [2:0]         BR_COND;
  logic               REG_WRITE;
  logic               MEM_READ;
  logic               MEM_WRITE;
  logic               IS_MDU;
  logic [2:0]         MDU_FUN;
  logic               ILLEGAL;
  logic               INT_TAKEN;
  logic [CAUSE_W-1:0] INT_CAUSE;

  modport master (
    output IN_VALID, INSTR, OUT_READY,
    input  IN_READY, OUT_VALID, ALU_FUN, ALU_SCRA,
    input  ALU_SCRB, RF_WR_SEL, PC_SOURCE, BR_COND,
    input  REG_WRITE, MEM_READ, MEM_WRITE, IS_MDU,
    input  MDU_FUN, ILLEGAL, INT_TAKEN, INT_CAUSE
  );

  modport slave (
    input  IN_VALID, INSTR, OUT_READY,
    output IN_READY, OUT_VALID, ALU_FUN, ALU_SCRA,
    output ALU_SCRB, RF_WR_SEL, PC_SOURCE, BR_COND,
    output REG_WRITE, MEM_READ, MEM_WRITE, IS_MDU,
    output MDU_FUN, ILLEGAL, INT_TAKEN, INT_CAUSE
  );

endinterface

// File: rtl/cu_int_arbiter.sv
// Fixed-priority interrupt encoder: index 0 wins.
// Ports: req in, any (nonzero request) out, cause (winning index) out.
module cu_int_arbiter #(
  parameter int NUM_INT = 4,
  parameter int CAUSE_W = 2
) (
  input  logic [NUM_INT-1:0] req,
  output logic               any,
  output logic [CAUSE_W-1:0] cause
);

  assign any = |req;

  always_comb begin
    cause = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (req[i]) cause = CAUSE_W'(i);
    end
  end

endmodule

// File: rtl/cu_decode_pipe.sv
// Registered decode stage with interrupt drain/trap sequencing.
// Ports: CLK, RST (sync high), FLUSH, INT_REQ, INT_EN, IN_TRAP, bus (slave).
// Optional build macro: CU_RV32M_EN enables multiply/divide decode.
module cu_decode_pipe
  import cu_pkg::*;
#(
  parameter int NUM_INT = 4,
  parameter int CAUSE_W =
    ($clog2(NUM_INT) > 0) ? $clog2(NUM_INT) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               FLUSH,
  input  logic [NUM_INT-1:0] INT_REQ,
  input  logic               INT_EN,
  output logic               IN_TRAP,
  cu_decode_pipe_if.slave    bus
);

  state_t             state_q;
  state_t             state_d;
  ctrl_bundle_t       out_q;
  ctrl_bundle_t       dec;
  ctrl_bundle_t       trap_b;
  logic               out_valid_q;
  logic [CAUSE_W-1:0] cause_q;
  logic [CAUSE_W-1:0] out_cause_q;
  logic               in_trap_q;
  logic [NUM_INT-1:0] masked;
  logic               any_req;
  logic [CAUSE_W-1:0] win;
  logic               drain_ok;
  logic               in_fire;
  logic               out_fire;

  assign masked = INT_REQ & {NUM_INT{INT_EN && !in_trap_q}};

  cu_int_arbiter #(
    .NUM_INT (NUM_INT),
    .CAUSE_W (CAUSE_W)
  ) u_arb (
    .req   (masked),
    .any   (any_req),
    .cause (win)
  );

  assign drain_ok = !out_valid_q || bus.OUT_READY;
  assign bus.IN_READY =
    (state_q == ST_RUN) && !any_req && drain_ok;
  assign in_fire  = bus.IN_VALID && bus.IN_READY;
  assign out_fire = out_valid_q && bus.OUT_READY;
  assign dec      = decode(bus.INSTR);

  always_comb begin
    trap_b           = '0;
    trap_b.int_taken = 1'b1;
    trap_b.pc_source = PC_TRAP;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (any_req) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_ok) state_d = ST_TRAP;
      ST_TRAP:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cause_q     <= '0;
      out_cause_q <= '0;
      in_trap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RUN && any_req) cause_q <= win;
      // A flushed MRET never retires, so it cannot unmask.
      if (state_q == ST_TRAP)
        in_trap_q <= 1'b1;
      else if (out_fire && !FLUSH && out_q.is_mret)
        in_trap_q <= 1'b0;
      // TRAP only follows an empty or drained register.
      if (state_q == ST_TRAP) begin
        out_q       <= trap_b;
        out_cause_q <= cause_q;
        out_valid_q <= 1'b1;
      end else if (FLUSH) begin
        if (!out_q.int_taken || bus.OUT_READY)
          out_valid_q <= 1'b0;
      end else if (in_fire) begin
        out_q       <= dec;
        out_cause_q <= '0;
        out_valid_q <= 1'b1;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign IN_TRAP       = in_trap_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.ALU_FUN   = out_q.alu_fun;
  assign bus.ALU_SCRA  = out_q.alu_scra;
  assign bus.ALU_SCRB  = out_q.alu_scrb;
  assign bus.RF_WR_SEL = out_q.rf_wr_sel;
  assign bus.PC_SOURCE = out_q.pc_source;
  assign bus.BR_COND   = out_q.br_cond;
  assign bus.REG_WRITE = out_q.reg_write;
  assign bus.MEM_READ  = out_q.mem_read;
  assign bus.MEM_WRITE = out_q.mem_write;
  assign bus.IS_MDU    = out_q.is_mdu;
  assign bus.MDU_FUN   = out_q.mdu_fun;
  assign bus.ILLEGAL   = out_q.illegal;
  assign bus.INT_TAKEN = out_q.int_taken;
  assign bus.INT_CAUSE = out_cause_q;

endmodule

// File: tb/tb_cu_decode_pipe.sv
// Scoreboard bench for cu_decode_pipe: directed scenarios then random traffic.
// Honours CU_RV32M_EN in its reference decode.
module tb_cu_decode_pipe;

  localparam int NUM_INT = 4;
  localparam int CW = 2;
  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_MRET = 32'h30200073;
  localparam logic [31:0] I_MUL  = 32'h02208033;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic FLUSH = 1'b0;
  logic INT_EN = 1'b0;
  logic [NUM_INT-1:0] INT_REQ = '0;
  logic IN_TRAP;

  cu_decode_pipe_if #(.NUM_INT(NUM_INT)) bus();

  cu_decode_pipe #(.NUM_INT(NUM_INT)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .FLUSH   (FLUSH),
    .INT_REQ (INT_REQ),
    .INT_EN  (INT_EN),
    .IN_TRAP (IN_TRAP),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] alu;
    logic       a;
    logic [1:0] b;
    logic [1:0] wr;
    logic [2:0] pc;
    logic [2:0] br;
    logic       rw, mr, mw, mdu;
    logic [2:0] mf;
    logic       ill, it;
    logic [CW-1:0] cause;
  } bun_t;

  typedef struct {
    bun_t b;
    bit   mret;
  } ent_t;

  int checks = 0;
  int failures = 0;

  // Decode table written field-by-field from the instruction rules.
  function automatic bun_t ref_dec(logic [31:0] i);
    bun_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    e  = '0;
    f3 = i[14:12];
    f7 = i[31:25];
    case (i[6:0])
      7'h37: begin e.alu = 9; e.a = 1; e.wr = 3; e.rw = 1; end
      7'h17: begin e.a = 1; e.b = 3; e.wr = 3; e.rw = 1; end
      7'h6F: begin e.pc = 3; e.wr = 0; e.rw = 1; end
      7'h67: begin e.pc = 1; e.wr = 0; e.rw = 1; end
      7'h63: begin
        e.pc = 2; e.br = f3;
        e.ill = (f3 == 2 || f3 == 3);
      end
      7'h03: begin e.b = 1; e.wr = 2; e.mr = 1; e.rw = 1; end
      7'h23: begin e.b = 2; e.mw = 1; end
      7'h13: begin
        e.alu = (f3 == 5) ? {f7[5], f3} : {1'b0, f3};
        e.b = 1; e.wr = 3; e.rw = 1;
      end
      7'h33: begin
        if (f7 == 7'd1) begin
`ifdef CU_RV32M_EN
          e.alu = {1'b0, f3}; e.mdu = 1; e.mf = f3;
          e.wr = 3; e.rw = 1;
`else
          e.ill = 1;
`endif
        end else begin
          e.alu = {f7[5], f3}; e.wr = 3; e.rw = 1;
        end
      end
      7'h73: begin
        e.alu = 9; e.wr = 1; e.rw = 1;
        e.pc = (f3 == 0) ? 3'd5 : 3'd0;
      end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  function automatic bun_t actual();
    bun_t a;
    a.alu = bus.ALU_FUN;   a.a  = bus.ALU_SCRA;
    a.b   = bus.ALU_SCRB;  a.wr = bus.RF_WR_SEL;
    a.pc  = bus.PC_SOURCE; a.br = bus.BR_COND;
    a.rw  = bus.REG_WRITE; a.mr = bus.MEM_READ;
    a.mw  = bus.MEM_WRITE; a.mdu = bus.IS_MDU;
    a.mf  = bus.MDU_FUN;   a.ill = bus.ILLEGAL;
    a.it  = bus.INT_TAKEN; a.cause = bus.INT_CAUSE;
    return a;
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: queue of bundles in the output slot plus
  // interrupt sequencing (0 run, 1 drain, 2 trap).
  ent_t q[$];
  bit   m_trap = 0;
  int   phase = 0;
  logic [CW-1:0] m_cause = '0;
  bit   seen_rst = 0;
  bit   just_rst = 0;

  always @(negedge CLK) begin
    logic [NUM_INT-1:0] masked;
    bit ready, cons, drain_go;
    ent_t n;
    masked = (INT_EN && !m_trap) ? INT_REQ : '0;
    ready  = (phase == 0) && (masked == 0) &&
             (q.size() == 0 || bus.OUT_READY);
    if (seen_rst) begin
      chk("out_valid", 64'(bus.OUT_VALID), 64'(q.size() != 0));
      chk("in_trap", 64'(IN_TRAP), 64'(m_trap));
      chk("in_ready", 64'(bus.IN_READY), 64'(ready));
      if (just_rst) chk("reset_bundle", 64'(actual()), 64'd0);
      if (bus.OUT_VALID && bus.OUT_READY && q.size() != 0)
        chk("bundle", 64'(actual()), 64'(q[0].b));
    end
    just_rst = 0;
    if (RST) begin
      q.delete();
      m_trap = 0; phase = 0; m_cause = '0;
      seen_rst = 1; just_rst = 1;
    end else if (seen_rst) begin
      cons     = (q.size() != 0) && bus.OUT_READY;
      drain_go = (q.size() == 0) || bus.OUT_READY;
      if (phase == 2) begin
        n.b = '0; n.b.pc = 4; n.b.it = 1; n.b.cause = m_cause;
        n.mret = 0;
        q.push_back(n);
        m_trap = 1;
        phase = 0;
      end else begin
        if (FLUSH) begin
          if (q.size() != 0 && (!q[0].b.it || bus.OUT_READY))
            void'(q.pop_front());
        end else begin
          if (cons) begin
            if (q[0].mret) m_trap = 0;
            void'(q.pop_front());
          end
          if (ready && bus.IN_VALID) begin
            n.b = ref_dec(bus.INSTR);
            n.mret = (bus.INSTR == I_MRET);
            q.push_back(n);
          end
        end
        if (phase == 0 && masked != 0) begin
          for (int i = NUM_INT - 1; i >= 0; i--)
            if (masked[i]) m_cause = CW'(i);
          phase = 1;
        end else if (phase == 1 && drain_go) begin
          phase = 2;
        end
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom % 16)
      0:  return I_ADD;
      1:  return I_BNE;
      2:  return 32'h0020A463;
      3:  return I_LW;
      4:  return 32'h0020A023;
      5:  return 32'h123450B7;
      6:  return 32'h00001117;
      7:  return 32'h008000EF;
      8:  return 32'h000080E7;
      9:  return 32'h4030D093;
      10: return 32'h403100B3;
      11: return I_MRET;
      12: return 32'h30529073;
      13: return 32'hFFFFFFFF;
      14: return I_MUL;
      default: return $urandom;
    endcase
  endfunction

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(logic [31:0] i);
    bus.IN_VALID = 1; bus.INSTR = i;
    cyc();
    bus.IN_VALID = 0;
  endtask

  initial begin
    bus.IN_VALID = 0; bus.INSTR = '0; bus.OUT_READY = 0;
    RST = 1;
    cyc(3);
    RST = 0;
    // plain ADD
    bus.OUT_READY = 1;
    send(I_ADD);
    cyc(2);
    // BNE held for three cycles with a waiting ADD
    bus.OUT_READY = 0;
    send(I_BNE);
    bus.IN_VALID = 1; bus.INSTR = I_ADD;
    cyc(3);
    bus.OUT_READY = 1;
    cyc();
    bus.IN_VALID = 0;
    cyc(2);
    // interrupt while a bundle is held, nesting masked until MRET
    bus.OUT_READY = 0;
    send(I_ADD);
    INT_EN = 1; INT_REQ = 4'b1010;
    cyc(3);
    bus.OUT_READY = 1;
    cyc();
    INT_REQ = 0;
    cyc(3);
    INT_REQ = 4'b0001;
    cyc(3);
    send(I_MRET);
    INT_REQ = 0;
    cyc(3);
    // flush a held LOAD with a concurrent instruction
    bus.OUT_READY = 0;
    send(I_LW);
    bus.IN_VALID = 1; bus.INSTR = I_ADD;
    FLUSH = 1; bus.OUT_READY = 1;
    cyc();
    FLUSH = 0; bus.IN_VALID = 0;
    cyc(2);
    // flush with a held trap bundle
    bus.OUT_READY = 0;
    INT_REQ = 4'b0100;
    cyc();
    INT_REQ = 0;
    cyc(2);
    FLUSH = 1;
    cyc();
    FLUSH = 0;
    cyc(2);
    bus.OUT_READY = 1;
    cyc();
    send(I_MRET);
    cyc(2);
    // illegal opcode and MUL
    send(32'hFFFFFFFF);
    send(I_MUL);
    cyc(2);
    // reset in DRAIN
    bus.OUT_READY = 0;
    send(I_ADD);
    INT_REQ = 4'b0001;
    cyc(2);
    RST = 1; INT_REQ = 0;
    cyc();
    RST = 0;
    cyc(2);
    // random traffic
    for (int k = 0; k < 4000; k++) begin
      RST = ($urandom % 400) == 0;
      bus.IN_VALID = ($urandom % 10) < 7;
      bus.INSTR = pick();
      bus.OUT_READY = ($urandom % 10) < 7;
      FLUSH = ($urandom % 20) == 0;
      INT_EN = ($urandom % 10) < 8;
      INT_REQ = (($urandom % 15) == 0) ? 4'($urandom) : 4'd0;
      cyc();
    end
    RST = 0; FLUSH = 0; INT_REQ = 0;
    bus.IN_VALID = 0; bus.OUT_READY = 1;
    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cu_decode_pipe.md
Name: cu_decode_pipe

Overview:
- Pipelined successor to the OTTER combinational control decoder; sits between the fetch and execute stages.
- Decodes a 32-bit instruction into a registered control bundle behind a valid/ready handshake.
- Branch conditions are deferred to execute as a condition code.
- Owns interrupt sequencing: arbitrates NUM_INT sources, drains the stage, injects one trap micro-op and masks nesting until MRET retires.

Parameters:
- NUM_INT, 4, number of interrupt request lines (1..16); index 0 has the highest priority.
- CAUSE_W, ($clog2(NUM_INT) > 0 ? $clog2(NUM_INT) : 1), width of INT_CAUSE.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  INSTR is valid.
- IN_READY  out  1  stage accepts INSTR this cycle.
- INSTR  in  32  raw instruction.
- FLUSH  in  1  discard the held non-trap entry (branch mispredict).
- INT_REQ  in  NUM_INT  level interrupt requests.
- INT_EN  in  1  global interrupt enable (mstatus.MIE).
- OUT_VALID  out  1  control bundle valid.
- OUT_READY  in  1  execute consumes the bundle.
- ALU_FUN  out  4  ALU operation.
- ALU_SCRA  out  1  ALU source A select.
- ALU_SCRB  out  2  ALU source B select.
- RF_WR_SEL  out  2  writeback select: 0 PC+4, 1 CSR, 2 memory, 3 ALU.
- PC_SOURCE  out  3  0 PC+4, 1 JALR, 2 conditional branch (resolved in execute), 3 JAL, 4 trap vector, 5 MEPC.
- BR_COND  out  3  FUNC3 of a branch, otherwise 0.
- REG_WRITE, MEM_READ, MEM_WRITE  out  1 each  side-effect enables.
- IS_MDU  out  1  multiply/divide op.
- MDU_FUN  out  3  MDU operation (FUNC3).
- ILLEGAL  out  1  unrecognised encoding.
- INT_TAKEN  out  1  bundle is a trap micro-op.
- INT_CAUSE  out  CAUSE_W  winning interrupt index.
- IN_TRAP  out  1  handler active; further interrupts masked.

Behaviour:
- Reset: OUT_VALID=0, every bundle field=0, IN_TRAP=0, state=RUN, captured cause=0.
- Decode table:
  - LUI: ALU_FUN 9, SCRA 1, WR_SEL 3.
  - AUIPC: SCRA 1, SCRB 3, WR_SEL 3.
  - JAL/JALR: PC_SOURCE 3/1, WR_SEL 0.
  - BRANCH: PC_SOURCE 2, BR_COND=FUNC3; FUNC3 2 or 3 flags ILLEGAL.
  - LOAD: SCRB 1, WR_SEL 2, MEM_READ.
  - STORE: SCRB 2, MEM_WRITE.
  - OP_IMM: ALU_FUN {FUNC3==5 ? FUNC7[5] : 0, FUNC3}, SCRB 1, WR_SEL 3.
  - OP: ALU_FUN {FUNC7[5], FUNC3}, WR_SEL 3.
  - SYSTEM: ALU_FUN 9, WR_SEL 1; FUNC3==0 gives PC_SOURCE 5.
  - REG_WRITE=1 for every writing class.
  - Any other opcode: ILLEGAL=1 with REG_WRITE, MEM_READ and MEM_WRITE all 0.
- Latency: one cycle; the bundle registers on the edge where IN_VALID and IN_READY are both high.
- Output hold: the bundle stays stable while OUT_VALID=1 and OUT_READY=0.
- Masked request: INT_REQ & {NUM_INT{INT_EN && !IN_TRAP}}.
- IN_READY = (state==RUN) && masked request==0 && (!OUT_VALID || OUT_READY).
- FSM:
  - RUN: a nonzero masked request latches the lowest set index as cause and moves to DRAIN. An instruction is never accepted on that edge; interrupt wins a tie with IN_VALID.
  - DRAIN: IN_READY=0. When the output register is empty or being consumed this cycle, move to TRAP.
  - TRAP: load a trap bundle (INT_TAKEN=1, PC_SOURCE=4, INT_CAUSE=latched cause, all enables 0), set IN_TRAP=1, return to RUN.
- IN_TRAP clears when an MRET (INSTR==32'h30200073) bundle transfers out. A request arriving that same cycle is seen on the next cycle.
- FLUSH:
  - Clears OUT_VALID unless the held bundle has INT_TAKEN=1; a trap bundle is never dropped.
  - Outranks a same-cycle transfer, whose input is dropped.
  - Does not change FSM state.
- Priority: RST > FLUSH > transfer.
- INT_REQ deasserting during DRAIN does not cancel the sequence; the latched cause is used.

Optional Feature:
- Macro: CU_RV32M_EN.
- Defined: OP with FUNC7==7'b0000001 decodes as IS_MDU=1, MDU_FUN=FUNC3, REG_WRITE=1, WR_SEL 3.
- Undefined: that encoding sets ILLEGAL=1; IS_MDU and MDU_FUN are tied to 0.

Decomposition:
- Package cu_pkg holds:
  - opcode_t enum;
  - PC_SOURCE, RF_WR_SEL and ALU_FUN localparams;
  - packed struct ctrl_bundle_t;
  - fsm state enum;
  - MRET constant.
- Sub-module cu_int_arbiter: combinational priority encoder producing the cause and an any-request flag, parametrised by NUM_INT.

Test Plan:
1. ADD x1,x2,x3 (32'h003100B3), OUT_READY=1 -> next cycle OUT_VALID=1, ALU_FUN 0, WR_SEL 3, REG_WRITE 1.
2. BNE (FUNC3=1) while OUT_READY=0 for 3 cycles -> bundle held stable with PC_SOURCE 2 and BR_COND 1; IN_READY=0 until consumed.
3. INT_EN=1, INT_REQ=4'b1010 with a held bundle -> DRAIN until the bundle is consumed, then a trap bundle with INT_CAUSE=1 and PC_SOURCE 4; IN_TRAP=1 and later requests ignored until MRET transfers, then IN_TRAP=0.
4. FLUSH with a held LOAD and a concurrent IN_VALID -> OUT_VALID=0 next cycle and the new instruction is dropped; FLUSH with a held trap bundle -> bundle kept.
5. Opcode 7'b1111111 -> ILLEGAL=1 and all enables 0; MUL 32'h02208033 -> IS_MDU=1 with the macro defined, ILLEGAL=1 without.
6. RST asserted in DRAIN -> next cycle state RUN, OUT_VALID=0, IN_TRAP=0.
